// File: rtl/poly_synth.sv
// rtl/poly_synth.sv - time-multiplexed polyphonic DDS synthesizer
// One wave generator and mixer walk NUM_VOICES phase accumulators once per sample tick.
module poly_synth #(
    parameter int NUM_VOICES = 8,
    parameter int PHASE_BITS = 32,
    parameter int WIDTH      = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          sample_tick_in,
    input  logic [1:0]                    mode_in,
    input  logic                          cfg_we_in,
    input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice_in,
    input  logic [PHASE_BITS-1:0]         cfg_incr_in,
    input  logic                          cfg_gate_in,
    input  logic                          overrun_clr_in,
    output logic [WIDTH-1:0]              sample_out,
    output logic                          sample_valid_out,
    output logic                          busy_out,
    output logic                          overrun_out
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int ACC_W = WIDTH + IDX_W;
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [IDX_W-1:0]        r_index;
    logic [1:0]              r_mode;
    logic signed [ACC_W-1:0] r_acc;
    logic [WIDTH-1:0]        r_sample;
    logic                    r_overrun;

    logic [PHASE_BITS-1:0]   r_phase [NUM_VOICES];
    logic [PHASE_BITS-1:0]   r_incr  [NUM_VOICES];
    logic                    r_gate  [NUM_VOICES];

    logic                    w_busy;
    logic                    w_valid;
    logic                    w_start;
    logic                    w_run;
    logic                    w_last;
    logic                    w_ovr_set;
    logic [PHASE_BITS-1:0]   w_phase_cur;
    logic [WIDTH-1:0]        w_p;
    logic [WIDTH-2:0]        w_tri_u;
    logic [WIDTH-1:0]        w_wave;
    logic [WIDTH-1:0]        w_contrib;
    logic signed [ACC_W-1:0] w_sum;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (sample_tick_in) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = (r_state != S_IDLE);
        w_valid = (r_state == S_DONE);
        w_run   = (r_state == S_RUN);
        w_start = (r_state == S_IDLE) && sample_tick_in;
    end

    assign w_last    = w_run && (r_index == LAST_IDX);
    assign w_ovr_set = sample_tick_in && w_busy;

    // Wave generator works on the top WIDTH bits of the pre-increment phase.
    assign w_phase_cur = r_phase[r_index];
    assign w_p         = w_phase_cur[PHASE_BITS-1 -: WIDTH];
    assign w_tri_u     = w_p[WIDTH-1] ? ~w_p[WIDTH-2:0] : w_p[WIDTH-2:0];

    always_comb begin
        w_wave = '0;
        case (r_mode)
            2'd0:    w_wave = w_p - HALF;
            2'd1:    w_wave = w_p[WIDTH-1] ? HALF : (HALF - 1'b1);
            2'd2:    w_wave = {w_tri_u, 1'b0} - HALF;
            default: w_wave = '0;
        endcase
    end

    assign w_contrib = r_gate[r_index] ? w_wave : '0;
    assign w_sum     = r_acc + {{IDX_W{w_contrib[WIDTH-1]}}, w_contrib};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_index  <= '0;
            r_mode   <= 2'd0;
            r_acc    <= '0;
            r_sample <= '0;
        end else begin
            if (w_start) begin
                r_index <= '0;
                r_mode  <= mode_in;
                r_acc   <= '0;
            end else if (w_run) begin
                r_index <= r_index + 1'b1;
                r_acc   <= w_sum;
            end
            // Top WIDTH bits of the final sum are the sum arithmetically shifted by IDX_W.
            if (w_last) begin
                r_sample <= w_sum[ACC_W-1 -: WIDTH];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_incr[i] <= '0;
                r_gate[i] <= 1'b0;
            end
        end else if (cfg_we_in) begin
            r_incr[cfg_voice_in] <= cfg_incr_in;
            r_gate[cfg_voice_in] <= cfg_gate_in;
        end
    end

    // Phase advances with the incr/gate seen this cycle; config writes never touch phase.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_phase[i] <= '0;
            end
        end else if (w_run) begin
            if (r_gate[r_index]) begin
                r_phase[r_index] <= w_phase_cur + r_incr[r_index];
            end else begin
                r_phase[r_index] <= '0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr_in) begin
            r_overrun <= 1'b0;
        end
    end

    assign sample_out       = r_sample;
    assign sample_valid_out = w_valid;
    assign busy_out         = w_busy;
    assign overrun_out      = r_overrun;

endmodule

// File: tb/tb_poly_synth.sv
// tb/tb_poly_synth.sv - self-checking bench for poly_synth
// Directed scenarios plus random traffic, checked every cycle against a sample-level model.
module tb_poly_synth;

    localparam int NV   = 4;
    localparam int PB   = 16;
    localparam int W    = 16;
    localparam int H    = 1 << (W - 1);
    localparam int MASK = (1 << PB) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          we = 1'b0;
    logic [1:0]    voice = 2'd0;
    logic [PB-1:0] incr = '0;
    logic          gate = 1'b0;
    logic          clr = 1'b0;
    logic [W-1:0]  sample;
    logic          valid;
    logic          busy;
    logic          ovr;

    poly_synth #(
        .NUM_VOICES(NV),
        .PHASE_BITS(PB),
        .WIDTH     (W)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .sample_tick_in  (tick),
        .mode_in         (mode),
        .cfg_we_in       (we),
        .cfg_voice_in    (voice),
        .cfg_incr_in     (incr),
        .cfg_gate_in     (gate),
        .overrun_clr_in  (clr),
        .sample_out      (sample),
        .sample_valid_out(valid),
        .busy_out        (busy),
        .overrun_out     (ovr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: per-voice config/phase, and cycles elapsed since the accepted tick (0 = idle).
    int m_phase [NV];
    int m_incr  [NV];
    bit m_gate  [NV];
    int m_since;
    int m_sum;
    int m_sample;
    int m_mode;
    bit m_ovr;

    function automatic int wave(input int md, input int ph);
        int p;
        int u;
        p = ph >> (PB - W);
        case (md)
            0: return p - H;
            1: return (p < H) ? H - 1 : -H;
            2: begin
                u = (p >= H) ? (H - 1) - (p - H) : p;
                return 2 * u - H;
            end
            default: return 0;
        endcase
    endfunction

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_phase[i] = 0;
            m_incr[i]  = 0;
            m_gate[i]  = 1'b0;
        end
        m_since = 0; m_sum = 0; m_sample = 0; m_mode = 0; m_ovr = 1'b0;
    endtask

    // One clock: check current outputs, drive inputs, advance model over the edge.
    task automatic cycle(input bit t, input bit w, input int v, input int inc, input bit g,
                         input bit c, input int md);
        int vi;
        check("busy", busy, (m_since != 0));
        check("valid", valid, (m_since == NV + 1));
        check("sample", $signed(sample), m_sample);
        check("overrun", ovr, m_ovr);
        tick = t; we = w; voice = v[1:0]; incr = inc[PB-1:0]; gate = g; clr = c; mode = md[1:0];
        if (m_since >= 1 && m_since <= NV) begin
            vi = m_since - 1;
            if (m_gate[vi]) begin
                m_sum = m_sum + wave(m_mode, m_phase[vi]);
                m_phase[vi] = (m_phase[vi] + m_incr[vi]) & MASK;
            end else begin
                m_phase[vi] = 0;
            end
            if (m_since == NV) m_sample = floor_div(m_sum, NV);
        end
        if (t && m_since != 0) m_ovr = 1'b1;
        else if (c) m_ovr = 1'b0;
        if (m_since == NV + 1) m_since = 0;
        else if (m_since != 0) m_since++;
        else if (t) begin
            m_since = 1; m_sum = 0; m_mode = md;
        end
        if (w) begin
            m_incr[v] = inc & MASK;
            m_gate[v] = g;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic write_voice(input int v, input int inc, input bit g);
        cycle(0, 1, v, inc, g, 0, 0);
    endtask

    task automatic write_all(input int inc, input bit g);
        for (int v = 0; v < NV; v++) write_voice(v, inc, g);
    endtask

    // Tick, then land exactly on the valid cycle and compare against a fixed value.
    task automatic tick_expect(input int md, input int exp, input string tag);
        cycle(1, 0, 0, 0, 0, 0, md);
        idle(NV);
        check({tag, "_valid"}, valid, 1);
        check(tag, $signed(sample), exp);
        idle(20 - NV - 1);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_sample", $signed(sample), 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", ovr, 0);
        rst = 1'b0;
        idle(2);

        write_voice(0, 'h4000, 1);
        tick_expect(0, -8192, "saw0");
        tick_expect(0, -4096, "saw1");
        tick_expect(0, 0,     "saw2");
        tick_expect(0, 4096,  "saw3");
        tick_expect(0, -8192, "saw_wrap");

        write_all(0, 0);
        tick_expect(1, 0, "sq_clear");
        write_all(0, 1);
        tick_expect(1, 32767, "sq_hi");
        write_all('h8000, 1);
        tick_expect(1, 32767, "sq_arm");
        tick_expect(1, -32768, "sq_lo");

        write_all(0, 0);
        tick_expect(2, 0, "tri_clear");
        write_voice(0, 'h4000, 1);
        tick_expect(2, -8192, "tri0");
        tick_expect(2, 0,     "tri1");
        tick_expect(2, 8191,  "tri2");
        tick_expect(2, -1,    "tri3");

        cycle(1, 0, 0, 0, 0, 0, 0);
        idle(1);
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle(2);
        check("ovr_single_valid", valid, 1);
        check("ovr_set", ovr, 1);
        idle(3);
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle(1);
        cycle(1, 0, 0, 0, 0, 1, 0);
        check("ovr_set_wins", ovr, 1);
        idle(5);
        cycle(0, 0, 0, 0, 0, 1, 0);
        check("ovr_clear", ovr, 0);

        write_all(0, 0);
        tick_expect(0, 0, "slot_clear");
        write_voice(2, 'h4000, 1);
        tick_expect(0, -8192, "slot_first");
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle(2);
        write_voice(2, 'h2000, 0);
        idle(1);
        check("slot_old_vals", $signed(sample), -4096);
        idle(14);
        tick_expect(0, 0, "slot_gate_off");
        write_voice(2, 'h4000, 1);
        tick_expect(0, -8192, "slot_phase_zero");

        write_all('h1234, 1);
        cycle(1, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 1);
        idle(1);
        rst = 1'b1;
        #1;
        check("midrst_sample", $signed(sample), 0);
        check("midrst_valid", valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overrun", ovr, 0);
        model_reset();
        @(posedge clk);
        #1;
        check("midrst_hold_valid", valid, 0);
        rst = 1'b0;
        idle(2);
        tick_expect(1, 0, "post_reset");

        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, NV - 1)),
                  int'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                  int'($urandom_range(0, 3)));
        end
        idle(NV + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
